// File: rtl/squash_seq_pkg.sv
// Shared types and helpers for the squash sequencer.
// Combinational helpers only; no state lives here.
// No flow control; pure functions and type definitions.
package squash_seq_pkg;

  // Redirect handshake state: nothing pending, or a redirect waiting for fetch.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } seq_state_e;

  // True when a is strictly older than b, judged by distance from the commit head.
  // Operands arrive zero-extended to 32 bits; n is the live width (must be < 32).
  function automatic logic age_older(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input logic [31:0] head,
                                     input int unsigned n);
    logic [31:0] mask;
    logic [31:0] off_a;
    logic [31:0] off_b;
    mask  = (32'h1 << n) - 32'h1;
    off_a = (a - head) & mask;
    off_b = (b - head) & mask;
    return off_a < off_b;
  endfunction

  // One ASCII hex digit for a nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

  // Trace text "ss:tttttttt" while a broadcast pulses, otherwise blanks.
  function automatic logic [8*11-1:0] linetrace(input logic        vld,
                                                input logic [7:0]  seq,
                                                input logic [31:0] tgt);
    logic [8*11-1:0] txt;
    txt = {11{8'h20}};
    if (vld) begin
      txt = {hex_char(seq[7:4]), hex_char(seq[3:0]), 8'h3a,
             hex_char(tgt[31:28]), hex_char(tgt[27:24]),
             hex_char(tgt[23:20]), hex_char(tgt[19:16]),
             hex_char(tgt[15:12]), hex_char(tgt[11:8]),
             hex_char(tgt[7:4]),   hex_char(tgt[3:0])};
    end
    return txt;
  endfunction

endpackage

// File: rtl/squash_seq_age_cmp.sv
// Head-relative age compare between two sequence numbers.
// Purely combinational, zero cycles.
// No flow control.
module squash_seq_age_cmp
  import squash_seq_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic [p_seq_num_bits-1:0] a,
  input  logic [p_seq_num_bits-1:0] b,
  input  logic [p_seq_num_bits-1:0] head,
  output logic                      older
);

  // Offsets from head decide age so the compare survives sequence-number wrap.
  always_comb begin
    older = age_older(32'(a), 32'(b), 32'(head), p_seq_num_bits);
  end

endmodule

// File: rtl/squash_sequencer.sv
// Registers the winning squash, filters stale ones, broadcasts the kill and holds the fetch redirect.
// One cycle from sq_val to bcast_val/redir_val; no combinational input-to-output paths.
// Never stalls sq_*; the redirect waits on redir_rdy and is overwritten only by an older squash.
module squash_sequencer
  import squash_seq_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [p_seq_num_bits-1:0] sq_seq_num,
  input  logic [31:0]               sq_target,
  input  logic                      sq_val,
  input  logic                      commit_val,
  output logic [p_seq_num_bits-1:0] bcast_seq_num,
  output logic [31:0]               bcast_target,
  output logic                      bcast_val,
  output logic [31:0]               redir_target,
  output logic                      redir_val,
  input  logic                      redir_rdy,
  output logic [p_seq_num_bits-1:0] head_seq_num
);

  logic [p_seq_num_bits-1:0] head;
  logic                      last_vld;
  logic [p_seq_num_bits-1:0] last_seq;
  logic                      sq_older;
  logic                      accept;
  seq_state_e                state;
  seq_state_e                state_nxt;

  squash_seq_age_cmp #(
    .p_seq_num_bits(p_seq_num_bits)
  ) u_age_cmp (
    .a    (sq_seq_num),
    .b    (last_seq),
    .head (head),
    .older(sq_older)
  );

  // A squash is taken when nothing is outstanding or it kills more than the last one did.
  always_comb begin
    accept = sq_val && (!last_vld || sq_older);
  end

  // Commit head advances one per in-order commit, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
    end else if (commit_val) begin
      head <= head + 1'b1;
    end
  end

  // Track the newest accepted squash; it retires once the squashing instruction commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_vld <= 1'b0;
      last_seq <= '0;
    end else if (accept) begin
      last_vld <= 1'b1;
      last_seq <= sq_seq_num;
    end else if (commit_val && last_vld && (head == last_seq)) begin
      last_vld <= 1'b0;
    end
  end

  // Broadcast pulses for exactly one cycle per accept; payload holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcast_val     <= 1'b0;
      bcast_seq_num <= '0;
      bcast_target  <= '0;
    end else begin
      bcast_val <= accept;
      if (accept) begin
        bcast_seq_num <= sq_seq_num;
        bcast_target  <= sq_target;
      end
    end
  end

  // Redirect target changes only on an accept, so it is stable while fetch is deciding.
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_target <= '0;
    end else if (accept) begin
      redir_target <= sq_target;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: an accept always leaves a redirect pending, even if fetch took the old one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = PEND;
      PEND: begin
        if (accept) begin
          state_nxt = PEND;
        end else if (redir_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: redirect valid purely from state, so no input reaches it combinationally.
  always_comb begin
    redir_val = (state == PEND);
  end

  // Debug view of the commit head.
  always_comb begin
    head_seq_num = head;
  end

endmodule
